// File: rtl/bootram_word_arbiter_if.sv
// Bus bundle between the CPU/loader side and the
// boot RAM, as seen by the word arbiter.
interface bootram_word_arbiter_if #(
  parameter int ADDR_WIDTH = 11
);
  logic                  cpu_valid;
  logic                  cpu_ready;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [3:0]            cpu_wstrb;
  logic [31:0]           cpu_wdata;
  logic [31:0]           cpu_rdata;
  logic                  ldr_valid;
  logic                  ldr_ready;
  logic [ADDR_WIDTH-1:0] ldr_addr;
  logic [7:0]            ldr_wdata;
  logic                  ram_ce;
  logic                  ram_oce;
  logic                  ram_wre;
  logic [ADDR_WIDTH-1:0] ram_ad;
  logic [7:0]            ram_din;
  logic [7:0]            ram_dout;

  modport slave (
    input  cpu_valid, cpu_addr, cpu_wstrb,
    input  cpu_wdata, ldr_valid, ldr_addr,
    input  ldr_wdata, ram_dout,
    output cpu_ready, cpu_rdata, ldr_ready,
    output ram_ce, ram_oce, ram_wre,
    output ram_ad, ram_din
  );

  modport master (
    output cpu_valid, cpu_addr, cpu_wstrb,
    output cpu_wdata, ldr_valid, ldr_addr,
    output ldr_wdata, ram_dout,
    input  cpu_ready, cpu_rdata, ldr_ready,
    input  ram_ce, ram_oce, ram_wre,
    input  ram_ad, ram_din
  );
endinterface

// File: rtl/bootram_word_arbiter.sv
// Round-robin arbiter turning CPU word accesses and
// loader byte writes into byte accesses on the boot RAM.
module bootram_word_arbiter #(
  parameter int ADDR_WIDTH = 11,
  parameter int RD_LATENCY = 1,
  parameter bit LDR_FIRST  = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  bootram_word_arbiter_if.slave bus
);

  localparam int A = ADDR_WIDTH;
  localparam logic [2:0] LAT  = 3'(RD_LATENCY);
  localparam logic [2:0] LAST = 3'(RD_LATENCY + 3);

  typedef enum logic [2:0] {
    IDLE, CPU_RD, CPU_WR, LDR_WR, DONE
  } state_t;

  state_t       state_q, state_d;
  logic [2:0]   cnt_q, cnt_d;
  logic [A-3:0] base_q, base_d;
  logic [3:0]   wstrb_q, wstrb_d;
  logic [31:0]  wdata_q, wdata_d;
  logic         rr_q, rr_d;
  logic [31:0]  rdata_q, rdata_d;
  logic         crdy_q, crdy_d;
  logic         lrdy_q, lrdy_d;
  logic         ce_q, ce_d;
  logic         wre_q, wre_d;
  logic         oce_q;
  logic [A-1:0] ad_q, ad_d;
  logic [7:0]   din_q, din_d;

  logic         gnt_ldr, gnt_cpu;
  logic [1:0]   nk, cidx;

  assign gnt_ldr = bus.ldr_valid &
                   (~bus.cpu_valid | rr_q);
  assign gnt_cpu = bus.cpu_valid & ~gnt_ldr;
  assign nk      = cnt_q[1:0] + 2'd1;
  assign cidx    = 2'(cnt_q - LAT);

  // state and datapath registers, sync reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      base_q  <= '0;
      wstrb_q <= '0;
      wdata_q <= '0;
      rr_q    <= LDR_FIRST;
      rdata_q <= '0;
      crdy_q  <= 1'b0;
      lrdy_q  <= 1'b0;
      ce_q    <= 1'b0;
      wre_q   <= 1'b0;
      oce_q   <= 1'b1;
      ad_q    <= '0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      wstrb_q <= wstrb_d;
      wdata_q <= wdata_d;
      rr_q    <= rr_d;
      rdata_q <= rdata_d;
      crdy_q  <= crdy_d;
      lrdy_q  <= lrdy_d;
      ce_q    <= ce_d;
      wre_q   <= wre_d;
      oce_q   <= 1'b1;
      ad_q    <= ad_d;
      din_q   <= din_d;
    end
  end

  // next state, grant and request latching
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    wstrb_d = wstrb_q;
    wdata_d = wdata_q;
    rr_d    = rr_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (gnt_ldr) begin
          state_d = LDR_WR;
          rr_d    = 1'b0;
        end else if (gnt_cpu) begin
          state_d = (bus.cpu_wstrb != 4'd0)
                    ? CPU_WR : CPU_RD;
          base_d  = bus.cpu_addr[A-1:2];
          wstrb_d = bus.cpu_wstrb;
          wdata_d = bus.cpu_wdata;
          rr_d    = 1'b1;
        end
      end
      CPU_RD: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == LAST) state_d = DONE;
      end
      CPU_WR: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd3) state_d = DONE;
      end
      LDR_WR:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // next values of the registered outputs
  always_comb begin
    crdy_d  = 1'b0;
    lrdy_d  = 1'b0;
    ce_d    = 1'b0;
    wre_d   = 1'b0;
    ad_d    = ad_q;
    din_d   = din_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_ldr) begin
          ce_d  = 1'b1;
          wre_d = 1'b1;
          ad_d  = bus.ldr_addr;
          din_d = bus.ldr_wdata;
        end else if (gnt_cpu) begin
          ad_d = {bus.cpu_addr[A-1:2], 2'b00};
          if (bus.cpu_wstrb != 4'd0) begin
            din_d = bus.cpu_wdata[7:0];
            ce_d  = bus.cpu_wstrb[0];
            wre_d = bus.cpu_wstrb[0];
          end else begin
            ce_d = 1'b1;
          end
        end
      end
      CPU_RD: begin
        if (cnt_q < 3'd3) ad_d = {base_q, nk};
        if (cnt_q >= LAT)
          rdata_d[{cidx, 3'b000} +: 8] = bus.ram_dout;
        if (cnt_q != LAST) ce_d = 1'b1;
        else crdy_d = 1'b1;
      end
      CPU_WR: begin
        if (cnt_q < 3'd3) begin
          ad_d  = {base_q, nk};
          din_d = wdata_q[{nk, 3'b000} +: 8];
          ce_d  = wstrb_q[nk];
          wre_d = wstrb_q[nk];
        end else begin
          crdy_d = 1'b1;
        end
      end
      LDR_WR:  lrdy_d = 1'b1;
      DONE:    ;
      default: ;
    endcase
  end

  assign bus.cpu_ready = crdy_q;
  assign bus.cpu_rdata = rdata_q;
  assign bus.ldr_ready = lrdy_q;
  assign bus.ram_ce    = ce_q;
  assign bus.ram_oce   = oce_q;
  assign bus.ram_wre   = wre_q;
  assign bus.ram_ad    = ad_q;
  assign bus.ram_din   = din_q;

endmodule

// File: tb/tb_bootram_word_arbiter.sv
// Directed bench for bootram_word_arbiter with
// byte-RAM models in bypass and pipelined read modes.
module tb_bootram_word_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   nerr = 0;
  int   nchk = 0;

  always #5 clk = ~clk;

  bootram_word_arbiter_if #(.ADDR_WIDTH(11)) b0();
  bootram_word_arbiter_if #(.ADDR_WIDTH(11)) b1();

  bootram_word_arbiter #(
    .ADDR_WIDTH(11), .RD_LATENCY(1), .LDR_FIRST(1'b1)
  ) u0 (.clk(clk), .reset(reset), .bus(b0.slave));

  bootram_word_arbiter #(
    .ADDR_WIDTH(11), .RD_LATENCY(2), .LDR_FIRST(1'b1)
  ) u1 (.clk(clk), .reset(reset), .bus(b1.slave));

  logic [7:0] mem0 [0:2047];
  logic [7:0] mem1 [0:2047];
  logic [7:0] dout0, raw1, dout1;

  // bypass-mode RAM for u0
  always @(posedge clk)
    if (b0.ram_ce) begin
      if (b0.ram_wre) mem0[b0.ram_ad] <= b0.ram_din;
      else dout0 <= mem0[b0.ram_ad];
    end

  // pipelined-mode RAM for u1
  always @(posedge clk) begin
    if (b1.ram_ce) begin
      if (b1.ram_wre) mem1[b1.ram_ad] <= b1.ram_din;
      else raw1 <= mem1[b1.ram_ad];
    end
    if (b1.ram_oce) dout1 <= raw1;
  end

  assign b0.ram_dout = dout0;
  assign b1.ram_dout = dout1;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic ldr_op0(input logic [10:0] a,
                         input logic [7:0] d);
    b0.ldr_addr  = a;
    b0.ldr_wdata = d;
    b0.ldr_valid = 1'b1;
    tick;
    chk("ldr_t1_ce", b0.ram_ce, 1);
    chk("ldr_t1_wre", b0.ram_wre, 1);
    chk("ldr_t1_ad", b0.ram_ad, a);
    chk("ldr_t1_din", b0.ram_din, d);
    chk("ldr_t1_rdy", b0.ldr_ready, 0);
    tick;
    chk("ldr_t2_rdy", b0.ldr_ready, 1);
    chk("ldr_t2_wre", b0.ram_wre, 0);
    chk("ldr_t2_ce", b0.ram_ce, 0);
    b0.ldr_valid = 1'b0;
    tick;
    chk("ldr_t3_rdy", b0.ldr_ready, 0);
    chk("ldr_t3_ce", b0.ram_ce, 0);
  endtask

  task automatic cpu_op0(input logic [10:0] a,
                         input logic [3:0] s,
                         input logic [31:0] wd,
                         input logic [31:0] exp_rd);
    int lat;
    int k;
    logic [10:0] base;
    lat  = (s != 4'd0) ? 5 : 6;
    base = {a[10:2], 2'b00};
    b0.cpu_addr  = a;
    b0.cpu_wstrb = s;
    b0.cpu_wdata = wd;
    b0.cpu_valid = 1'b1;
    for (int t = 1; t <= lat; t++) begin
      tick;
      if (t < lat) begin
        k = (t > 4) ? 3 : t - 1;
        chk($sformatf("cpu_t%0d_rdy", t),
            b0.cpu_ready, 0);
        chk($sformatf("cpu_t%0d_ad", t),
            b0.ram_ad, 32'(base) | 32'(k));
        if (s != 4'd0) begin
          chk($sformatf("cpu_t%0d_ce", t),
              b0.ram_ce, s[k]);
          chk($sformatf("cpu_t%0d_wre", t),
              b0.ram_wre, s[k]);
          chk($sformatf("cpu_t%0d_din", t),
              b0.ram_din, wd[8*k +: 8]);
        end else begin
          chk($sformatf("cpu_t%0d_ce", t),
              b0.ram_ce, 1);
          chk($sformatf("cpu_t%0d_wre", t),
              b0.ram_wre, 0);
        end
      end else begin
        chk("cpu_done_rdy", b0.cpu_ready, 1);
        chk("cpu_done_ce", b0.ram_ce, 0);
        chk("cpu_done_wre", b0.ram_wre, 0);
        chk("cpu_done_rdata", b0.cpu_rdata, exp_rd);
      end
    end
    b0.cpu_valid = 1'b0;
    tick;
    chk("cpu_idle_rdy", b0.cpu_ready, 0);
    chk("cpu_hold_rdata", b0.cpu_rdata, exp_rd);
  endtask

  int n;
  logic [1:0] ord [4];

  initial begin
    b0.cpu_valid = 1'b0;
    b0.cpu_addr  = '0;
    b0.cpu_wstrb = '0;
    b0.cpu_wdata = '0;
    b0.ldr_valid = 1'b0;
    b0.ldr_addr  = '0;
    b0.ldr_wdata = '0;
    b1.cpu_valid = 1'b0;
    b1.cpu_addr  = '0;
    b1.cpu_wstrb = '0;
    b1.cpu_wdata = '0;
    b1.ldr_valid = 1'b0;
    b1.ldr_addr  = '0;
    b1.ldr_wdata = '0;
    mem1[16] = 8'hEF;
    mem1[17] = 8'hBE;
    mem1[18] = 8'h77;
    mem1[19] = 8'hDE;

    reset = 1'b1;
    tick;
    tick;
    chk("rst_cpu_ready", b0.cpu_ready, 0);
    chk("rst_ldr_ready", b0.ldr_ready, 0);
    chk("rst_rdata", b0.cpu_rdata, 0);
    chk("rst_ce", b0.ram_ce, 0);
    chk("rst_wre", b0.ram_wre, 0);
    chk("rst_ad", b0.ram_ad, 0);
    chk("rst_din", b0.ram_din, 0);
    chk("rst_oce", b0.ram_oce, 1);
    reset = 1'b0;
    tick;

    ldr_op0(11'h010, 8'hA5);

    cpu_op0(11'h013, 4'b1111, 32'hDEADBEEF, 32'h0);
    cpu_op0(11'h010, 4'b0000, 32'h0, 32'hDEADBEEF);

    cpu_op0(11'h010, 4'b0100, 32'h00770000,
            32'hDEADBEEF);
    cpu_op0(11'h010, 4'b0000, 32'h0, 32'hDE77BEEF);

    ldr_op0(11'h030, 8'h5A);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    b0.cpu_addr  = 11'h010;
    b0.cpu_wstrb = 4'd0;
    b0.ldr_addr  = 11'h020;
    b0.ldr_wdata = 8'h11;
    b0.cpu_valid = 1'b1;
    b0.ldr_valid = 1'b1;
    n = 0;
    for (int c = 0; c < 100 && n < 4; c++) begin
      tick;
      if (b0.ldr_ready && n < 4) begin
        ord[n] = 2'd1;
        n++;
      end
      if (b0.cpu_ready && n < 4) begin
        ord[n] = 2'd2;
        n++;
      end
    end
    b0.cpu_valid = 1'b0;
    b0.ldr_valid = 1'b0;
    chk("arb_count", n, 4);
    if (n == 4) begin
      chk("arb_grant0", ord[0], 1);
      chk("arb_grant1", ord[1], 2);
      chk("arb_grant2", ord[2], 1);
      chk("arb_grant3", ord[3], 2);
    end
    tick;
    tick;

    b0.cpu_addr  = 11'h010;
    b0.cpu_wstrb = 4'd0;
    b0.cpu_valid = 1'b1;
    tick;
    tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    b0.cpu_valid = 1'b0;
    chk("mrst_ce", b0.ram_ce, 0);
    chk("mrst_rdata", b0.cpu_rdata, 0);
    chk("mrst_rdy", b0.cpu_ready, 0);
    chk("mrst_ad", b0.ram_ad, 0);
    for (int c = 0; c < 8; c++) begin
      tick;
      chk($sformatf("mrst_norel%0d", c),
          b0.cpu_ready, 0);
    end
    cpu_op0(11'h010, 4'b0000, 32'h0, 32'hDE77BEEF);

    b1.cpu_addr  = 11'h012;
    b1.cpu_wstrb = 4'd0;
    b1.cpu_valid = 1'b1;
    for (int t = 1; t <= 6; t++) begin
      tick;
      chk($sformatf("l2_t%0d_rdy", t),
          b1.cpu_ready, 0);
      chk($sformatf("l2_t%0d_ce", t), b1.ram_ce, 1);
      chk($sformatf("l2_t%0d_ad", t), b1.ram_ad,
          32'h10 | ((t > 4) ? 3 : t - 1));
    end
    tick;
    chk("l2_t7_rdy", b1.cpu_ready, 1);
    chk("l2_t7_rdata", b1.cpu_rdata, 32'hDE77BEEF);
    chk("l2_t7_ce", b1.ram_ce, 0);
    b1.cpu_valid = 1'b0;
    tick;
    chk("l2_idle_rdy", b1.cpu_ready, 0);

    $display("Result: errors=%0d of %0d checks",
             nerr, nchk);
    $finish;
  end

endmodule

// File: doc/bootram_word_arbiter.md
Name: bootram_word_arbiter

Overview:
- Two-port arbiter and sequencer in front of the 2Kx8 single-port boot RAM (SP primitive, byte wide, synchronous reset).
- Port 1 is the CPU: PicoRV32-style 32-bit word port with valid/ready, rdata and wstrb. Each word access becomes four byte accesses to the RAM.
- Port 2 is the boot loader, fed from UART: single-byte write port.
- Sits between the CPU bus decoder/loader FSM and the bootram instance.

Parameters:
- ADDR_WIDTH, 11, byte address width of the RAM.
- RD_LATENCY, 1, RAM read latency in cycles: 1 = bypass read mode, 2 = pipelined (output register) mode. Only 1 and 2 are legal.
- LDR_FIRST, 1, initial round-robin pointer: 1 = loader wins the first tie after reset, 0 = CPU wins.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cpu_valid  in  1  CPU request; held high until cpu_ready.
- cpu_ready  out  1  one-cycle completion pulse.
- cpu_addr  in  ADDR_WIDTH  byte address; [1:0] ignored.
- cpu_wstrb  in  4  byte write strobes; 0 = read.
- cpu_wdata  in  32  write data, little-endian.
- cpu_rdata  out  32  read data; valid while cpu_ready is high.
- ldr_valid  in  1  loader write request; held until ldr_ready.
- ldr_ready  out  1  one-cycle completion pulse.
- ldr_addr  in  ADDR_WIDTH  byte address.
- ldr_wdata  in  8  write byte.
- ram_ce  out  1  RAM clock enable.
- ram_oce  out  1  RAM output-register enable; constant 1.
- ram_wre  out  1  RAM write enable.
- ram_ad  out  ADDR_WIDTH  RAM byte address.
- ram_din  out  8  RAM write data.
- ram_dout  in  8  RAM read data.

Behaviour:
- All outputs are registered.
- Reset values: cpu_ready=0, ldr_ready=0, cpu_rdata=0, ram_ce=0, ram_wre=0, ram_ad=0, ram_din=0, ram_oce=1. FSM goes to IDLE; rr pointer = LDR_FIRST.
- FSM states: IDLE, CPU_RD, CPU_WR, LDR_WR, DONE.
- IDLE, arbitration (cycle T0):
  - Only one requester valid: grant it.
  - Both valid: grant the side the rr pointer names, then flip the pointer to the other side.
  - A single-requester grant also sets the pointer to the other side.
  - CPU grant: base = {cpu_addr[A-1:2],2'b00}; latch wstrb and wdata; go to CPU_WR if wstrb!=0, else CPU_RD.
  - Loader grant: go to LDR_WR.
- CPU_RD:
  - Cycles T1..T4: ram_ce=1, ram_wre=0, ram_ad = base|k for k=0..3.
  - Byte k is captured from ram_dout at the clock edge ending T(1+k+RD_LATENCY) into cpu_rdata[8k+7:8k].
  - ram_ce stays 1 through the capture window, with ram_ad held at its last value.
  - After the last capture, go to DONE. cpu_ready is high in T(5+RD_LATENCY), i.e. T6 when RD_LATENCY=1.
- CPU_WR:
  - Cycles T1..T4: ram_ad = base|k, ram_din = wdata[8k+7:8k], ram_ce = ram_wre = wstrb[k].
  - cpu_ready is high in T5. cpu_rdata is unchanged by writes.
- LDR_WR:
  - T1: ram_ce=1, ram_wre=1, ram_ad=ldr_addr, ram_din=ldr_wdata.
  - ldr_ready is high in T2.
- DONE:
  - Ready pulse cycle; ram_ce=0, ram_wre=0.
  - Next state is IDLE. The earliest next grant is the cycle after DONE, so there is a minimum of 1 idle cycle between transactions.
- cpu_rdata holds its value after cpu_ready until the next CPU read completes.
- No address wraps inside a word: base|k stays within the same aligned word.
- Loader addresses are used unmodified.
- Requests are sampled only in IDLE. A valid dropped mid-transaction does not abort it; the transaction completes and ready still pulses.
- Reset mid-transaction:
  - The next cycle shows reset values and ram_ce=0; no ready pulse is emitted.
  - Bytes already written stay in the RAM.
- ram_ce and ram_wre are never high in IDLE or DONE.

Test Plan:
- Reset, then loader writes 0xA5 to addr 0x010 -> ram_wre high for exactly 1 cycle with ram_ad=0x010, ram_din=0xA5; ldr_ready pulses 2 cycles after acceptance.
- CPU write addr 0x013, wstrb=4'b1111, wdata=0xDEADBEEF, then read 0x010 with RD_LATENCY=1 -> write hits ram_ad 0x010..0x013 with bytes EF,BE,AD,DE; the read returns cpu_rdata=0xDEADBEEF with cpu_ready in T6.
- CPU write wstrb=4'b0100, wdata=0x00770000 to 0x010, then read -> cpu_rdata=0xDE77BEEF; ram_wre is high only on the ram_ad=0x012 cycle.
- cpu_valid and ldr_valid both held high for 4 transactions after reset with LDR_FIRST=1 -> grant order loader, CPU, loader, CPU.
- Reset asserted in T2 of a CPU read -> next cycle has ram_ce=0, cpu_rdata=0, no cpu_ready; a fresh read afterwards returns the correct word.
- RD_LATENCY=2 model, read of 0x010 -> cpu_ready in T7 and cpu_rdata correct.
